// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: state encoding and default data width.
package counter_sequencer_pkg;

   localparam int W_DEFAULT = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DONE  = 3'd3,
      ST_CLEAR = 3'd4
   } state_t;

endpackage

// File: rtl/counter_sequencer.sv
// Command-driven initiator for the up/down counter: loads a start value, steps the
// counter len+1 compares, checks every returned count and reports done/err/err_at.
module counter_sequencer
   import counter_sequencer_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [W-1:0] cmd_start,
   input  logic         cmd_dir,
   input  logic [W-1:0] cmd_len,
   input  logic         abort,
   output logic         ctr_clr,
   output logic         ctr_ld,
   output logic         ctr_mode,
   output logic [W-1:0] ctr_din,
   input  logic [W-1:0] ctr_count,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [W-1:0] err_at
);

   state_t         state_reg, state_next;
   logic [W-1:0]   start_reg, start_next;
   logic           dir_reg, dir_next;
   logic [W-1:0]   len_reg, len_next;
   logic [W-1:0]   exp_reg, exp_next;
   logic [W-1:0]   rem_reg, rem_next;
   logic           run_err_reg, run_err_next;
   logic [W-1:0]   run_err_at_reg, run_err_at_next;
   logic           err_reg, err_next;
   logic [W-1:0]   err_at_reg, err_at_next;

   logic           mismatch;
   logic [W-1:0]   run_idx;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_reg      <= ST_IDLE;
         start_reg      <= '0;
         dir_reg        <= 1'b0;
         len_reg        <= '0;
         exp_reg        <= '0;
         rem_reg        <= '0;
         run_err_reg    <= 1'b0;
         run_err_at_reg <= '0;
         err_reg        <= 1'b0;
         err_at_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         start_reg      <= start_next;
         dir_reg        <= dir_next;
         len_reg        <= len_next;
         exp_reg        <= exp_next;
         rem_reg        <= rem_next;
         run_err_reg    <= run_err_next;
         run_err_at_reg <= run_err_at_next;
         err_reg        <= err_next;
         err_at_reg     <= err_at_next;
      end
   end

   // rem counts down from len, so the 0-based RUN index is len - rem.
   assign run_idx  = len_reg - rem_reg;
   assign mismatch = (state_reg == ST_RUN) && (ctr_count != exp_reg);

   always_comb begin
      state_next      = state_reg;
      start_next      = start_reg;
      dir_next        = dir_reg;
      len_next        = len_reg;
      exp_next        = exp_reg;
      rem_next        = rem_reg;
      run_err_next    = run_err_reg;
      run_err_at_next = run_err_at_reg;
      err_next        = err_reg;
      err_at_next     = err_at_reg;

      case (state_reg)
         ST_IDLE: begin
            if (cmd_valid) begin
               start_next  = cmd_start;
               dir_next    = cmd_dir;
               len_next    = cmd_len;
               err_next    = 1'b0;
               err_at_next = '0;
               state_next  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            exp_next        = start_reg;
            rem_next        = len_reg;
            run_err_next    = 1'b0;
            run_err_at_next = '0;
            state_next      = abort ? ST_CLEAR : ST_RUN;
         end
         ST_RUN: begin
            exp_next = dir_reg ? (exp_reg + W'(1)) : (exp_reg - W'(1));
            if (mismatch && !run_err_reg) begin
               run_err_next    = 1'b1;
               run_err_at_next = run_idx;
            end
            if (abort) begin
               state_next = ST_CLEAR;
            end else if (rem_reg == '0) begin
               // Commit the working result, including this cycle's compare.
               err_next    = run_err_next;
               err_at_next = run_err_at_next;
               state_next  = ST_DONE;
            end else begin
               rem_next = rem_reg - W'(1);
            end
         end
         ST_DONE:  state_next = abort ? ST_CLEAR : ST_IDLE;
         ST_CLEAR: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Counter-side outputs decode straight from state so reset drops them immediately.
   assign cmd_ready = (state_reg == ST_IDLE);
   assign busy      = (state_reg != ST_IDLE);
   assign done      = (state_reg == ST_DONE) && !abort;
   assign ctr_ld    = (state_reg == ST_LOAD);
   assign ctr_din   = (state_reg == ST_LOAD) ? start_reg : '0;
   assign ctr_mode  = ((state_reg == ST_LOAD) || (state_reg == ST_RUN)) ? dir_reg : 1'b0;
   assign ctr_clr   = (state_reg == ST_CLEAR);
   assign err       = err_reg;
   assign err_at    = err_at_reg;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer with an up/down counter partner and a force hook on ctr_count.
module tb_counter_sequencer;

   logic       clk = 1'b0;
   logic       clr_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_start;
   logic       cmd_dir;
   logic [7:0] cmd_len;
   logic       abort;
   logic       ctr_clr;
   logic       ctr_ld;
   logic       ctr_mode;
   logic [7:0] ctr_din;
   logic [7:0] ctr_count;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] err_at;

   logic [7:0] cnt_reg;
   logic       force_en;
   logic [7:0] force_val;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic       err;
      logic [7:0] err_at;
      int         done_cyc;
      string      name;
   } exp_t;
   exp_t sb[$];

   counter_sequencer #(.W(8)) dut (
      .clk(clk), .clr_n(clr_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_len(cmd_len),
      .abort(abort),
      .ctr_clr(ctr_clr), .ctr_ld(ctr_ld), .ctr_mode(ctr_mode), .ctr_din(ctr_din),
      .ctr_count(ctr_count),
      .busy(busy), .done(done), .err(err), .err_at(err_at)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Partner up/down counter: clr beats ld beats count.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)       cnt_reg <= 8'h00;
      else if (ctr_clr) cnt_reg <= 8'h00;
      else if (ctr_ld)  cnt_reg <= ctr_din;
      else if (ctr_mode) cnt_reg <= cnt_reg + 8'h01;
      else              cnt_reg <= cnt_reg - 8'h01;
   end
   assign ctr_count = force_en ? force_val : cnt_reg;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse consumes one scoreboard entry.
   always @(negedge clk) begin
      if (clr_n && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending command (cyc %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("txn %s: err=%0d err_at=%0d done_cyc=%0d", e.name, err, err_at, cyc);
            chk({e.name, "_err"}, 32'(err), 32'(e.err));
            chk({e.name, "_err_at"}, 32'(err_at), 32'(e.err_at));
            chk({e.name, "_latency"}, 32'(cyc), 32'(e.done_cyc));
         end
      end
   end

   // Called just after a negedge; returns at the negedge after the accept edge (LOAD),
   // leaving cmd_valid high. c is the cycle in which the handshake was seen.
   task automatic issue(input logic [7:0] s, input logic d, input logic [7:0] l,
                        input bit push, input logic e_err, input logic [7:0] e_at,
                        input string name, output int c);
      int k;
      cmd_start = s;
      cmd_dir   = d;
      cmd_len   = l;
      cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!cmd_ready) chk({name, "_accept_timeout"}, 32'(cmd_ready), 32'd1);
      c = cyc;
      if (push) sb.push_back('{e_err, e_at, c + int'(l) + 3, name});
      @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (!cmd_ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_idle"}, 32'(cmd_ready), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, c1, c2;
      logic [7:0] dn_vals [4];
      clr_n = 1'b0; cmd_valid = 1'b0; cmd_start = '0; cmd_dir = 1'b0; cmd_len = '0;
      abort = 1'b0; force_en = 1'b0; force_val = '0;
      dn_vals[0] = 8'h01; dn_vals[1] = 8'h00; dn_vals[2] = 8'hFF; dn_vals[3] = 8'hFE;

      #2;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_err_at", 32'(err_at), 32'd0);
      chk("rst_ctr", 32'({ctr_clr, ctr_ld, ctr_mode, ctr_din}), 32'd0);
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);

      // 1: count up 0A..0E
      issue(8'h0A, 1'b1, 8'd4, 1'b1, 1'b0, 8'h00, "up_basic", c);
      cmd_valid = 1'b0;
      chk("t1_ld", 32'(ctr_ld), 32'd1);
      chk("t1_din", 32'(ctr_din), 32'h0A);
      chk("t1_mode", 32'(ctr_mode), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("t1_count%0d", i), 32'(ctr_count), 32'h0A + 32'(i));
         chk($sformatf("t1_ld_low%0d", i), 32'(ctr_ld), 32'd0);
      end
      wait_idle("t1");

      // 2: count down across 00 -> FF
      issue(8'h01, 1'b0, 8'd3, 1'b1, 1'b0, 8'h00, "down_wrap", c);
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("t2_count%0d", i), 32'(ctr_count), 32'(dn_vals[i]));
         chk($sformatf("t2_mode%0d", i), 32'(ctr_mode), 32'd0);
      end
      wait_idle("t2");

      // 3: forced mismatch at RUN index 2 while wrapping up through FF -> 00
      issue(8'hFE, 1'b1, 8'd3, 1'b1, 1'b1, 8'd2, "forced_err", c);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      force_en  = 1'b1;
      force_val = 8'h55;
      @(negedge clk);
      force_en  = 1'b0;
      wait_idle("t3");

      // 4: abort in RUN index 2
      issue(8'h10, 1'b1, 8'd8, 1'b0, 1'b0, 8'h00, "abort", c);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t4_clr", 32'(ctr_clr), 32'd1);
      chk("t4_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t4_clr_gone", 32'(ctr_clr), 32'd0);
      chk("t4_count_zero", 32'(ctr_count), 32'd0);
      chk("t4_ready", 32'(cmd_ready), 32'd1);
      chk("t4_err", 32'(err), 32'd0);
      repeat (3) @(negedge clk);

      // 5: asynchronous reset mid-RUN
      issue(8'h20, 1'b1, 8'd8, 1'b0, 1'b0, 8'h00, "reset_mid", c);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5_mode_before", 32'(ctr_mode), 32'd1);
      chk("t5_busy_before", 32'(busy), 32'd1);
      #2 clr_n = 1'b0;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_ctr", 32'({ctr_clr, ctr_ld, ctr_mode, ctr_din}), 32'd0);
      @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);
      chk("t5_ready", 32'(cmd_ready), 32'd1);

      // 6: cmd_valid held across two commands, len 0 then len 1
      issue(8'h30, 1'b1, 8'd0, 1'b1, 1'b0, 8'h00, "len0", c1);
      issue(8'h30, 1'b1, 8'd1, 1'b1, 1'b0, 8'h00, "len1", c2);
      cmd_valid = 1'b0;
      chk("t6_accept_after_done", 32'(c2), 32'(c1 + 4));
      wait_idle("t6");

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
